// File: rtl/spr_pwl_pkg.sv
// ----------------------------------------------------------------------------
// spr_pwl_pkg
// Shared definitions for the SPR re-gamma piecewise-linear segment locator:
//   - default geometry localparams (pixel width, segment count, channel count)
//   - configuration FSM state encoding
//   - default breakpoint generator (evenly spaced table, bp[k] = k * step)
// ----------------------------------------------------------------------------
package spr_pwl_pkg;

   localparam int PWL_DATA_W  = 10;
   localparam int PWL_NUM_SEG = 32;
   localparam int PWL_CH      = 3;

   typedef enum logic [1:0] {
      CFG_IDLE    = 2'd0,
      CFG_CHECK   = 2'd1,
      CFG_WAIT_VS = 2'd2
   } cfg_state_t;

   // Evenly spaced table covering the full pixel range.
   function automatic int default_bp(input int k, input int data_w, input int num_seg);
      return k * ((1 << data_w) / num_seg);
   endfunction

endpackage

// File: rtl/pwl_seg_encoder.sv
// ----------------------------------------------------------------------------
// pwl_seg_encoder
// Per-channel segment decode. Takes the registered compare mask
// (mask[k] = bp[k] <= pix) and turns it into the segment index (highest set
// bit), the segment bounds from the active table and the in-segment offset.
// Purely combinational; the caller registers the results.
// Ports:
//   mask    in   NUM_SEG             compare mask, bit k = (bp[k] <= pix)
//   pix     in   DATA_W              pixel the mask was built from
//   bp_flat in   NUM_SEG*DATA_W      active breakpoint table, bp[0] in LSBs
//   idx     out  IDX_W               segment index
//   low     out  DATA_W              bp[idx]
//   high    out  DATA_W+1            bp[idx+1], 2**DATA_W for the last segment
//   frac    out  DATA_W              pix - low
// ----------------------------------------------------------------------------
module pwl_seg_encoder
   import spr_pwl_pkg::*;
#(
   parameter int DATA_W  = PWL_DATA_W,
   parameter int NUM_SEG = PWL_NUM_SEG,
   parameter int IDX_W   = $clog2(NUM_SEG)
) (
   input  logic [NUM_SEG-1:0]        mask,
   input  logic [DATA_W-1:0]         pix,
   input  logic [NUM_SEG*DATA_W-1:0] bp_flat,
   output logic [IDX_W-1:0]          idx,
   output logic [DATA_W-1:0]         low,
   output logic [DATA_W:0]           high,
   output logic [DATA_W-1:0]         frac
);

   logic [DATA_W-1:0] bp [NUM_SEG];
   logic [IDX_W-1:0]  idx_nxt;

   always_comb begin
      for (int k = 0; k < NUM_SEG; k++) begin
         bp[k] = bp_flat[k*DATA_W +: DATA_W];
      end
   end

   // The table is strictly increasing, so the mask is a thermometer code;
   // the last set bit wins.
   always_comb begin
      idx = '0;
      for (int k = 0; k < NUM_SEG; k++) begin
         if (mask[k]) begin
            idx = IDX_W'(k);
         end
      end
   end

   // idx_nxt wraps for the last segment; that case is overridden below.
   assign idx_nxt = idx + IDX_W'(1);

   always_comb begin
      low = bp[idx];
      if (idx == IDX_W'(NUM_SEG-1)) begin
         high = {1'b1, {DATA_W{1'b0}}};
      end else begin
         high = {1'b0, bp[idx_nxt]};
      end
      // low <= pix by construction, so this never wraps.
      frac = pix - low;
   end

endmodule

// File: rtl/pwl_segment_search.sv
// ----------------------------------------------------------------------------
// pwl_segment_search
// Multi-channel piecewise-linear segment locator for the SPR re-gamma path.
// All channels share one double-buffered breakpoint table. The shadow table is
// written through the cfg port, checked for strict monotonicity on commit and
// copied into the active table during vertical blanking, so a frame never sees
// two tables. Any blanking cycle (i_hs=0 or i_vs=0) flushes the pipeline.
// Ports:
//   clk, rst           clock, async active-high reset
//   i_hs, i_vs         sync inputs, 0 = blanking
//   en, pix_in         input valid and CH pixels (ch0 in LSBs)
//   cfg_we/addr/data   shadow table write (addr 0 ignored, bp[0] is always 0)
//   cfg_commit         start monotonicity check and swap
//   cfg_busy           check or swap pending
//   cfg_err            last commit rejected, sticky until the next commit
//   o_valid            en delayed by 2 clocks
//   o_idx/o_pix/o_low/o_high/o_frac  per-channel segment results
// ----------------------------------------------------------------------------
module pwl_segment_search
   import spr_pwl_pkg::*;
#(
   parameter int DATA_W  = PWL_DATA_W,
   parameter int NUM_SEG = PWL_NUM_SEG,
   parameter int IDX_W   = $clog2(NUM_SEG),
   parameter int CH      = PWL_CH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_hs,
   input  logic                    i_vs,
   input  logic                    en,
   input  logic [CH*DATA_W-1:0]    pix_in,
   input  logic                    cfg_we,
   input  logic [IDX_W-1:0]        cfg_addr,
   input  logic [DATA_W-1:0]       cfg_data,
   input  logic                    cfg_commit,
   output logic                    cfg_busy,
   output logic                    cfg_err,
   output logic                    o_valid,
   output logic [CH*IDX_W-1:0]     o_idx,
   output logic [CH*DATA_W-1:0]    o_pix,
   output logic [CH*DATA_W-1:0]    o_low,
   output logic [CH*(DATA_W+1)-1:0] o_high,
   output logic [CH*DATA_W-1:0]    o_frac
);

   logic [DATA_W-1:0]         active_bp [NUM_SEG];
   logic [DATA_W-1:0]         shadow_bp [NUM_SEG];
   logic [NUM_SEG*DATA_W-1:0] active_flat;

   cfg_state_t       state, state_nxt;
   logic [IDX_W-1:0] chk_k;
   logic [IDX_W-1:0] chk_k_nxt;
   logic             err_q;
   logic             shadow_we, chk_step, err_set, err_clr, swap;

   logic blank;

   logic                    vld_p1;
   logic [CH*DATA_W-1:0]    pix_p1;
   logic [CH*NUM_SEG-1:0]   mask_p1;
   logic [CH*NUM_SEG-1:0]   mask_nxt;

   logic [CH*IDX_W-1:0]      enc_idx;
   logic [CH*DATA_W-1:0]     enc_low;
   logic [CH*(DATA_W+1)-1:0] enc_high;
   logic [CH*DATA_W-1:0]     enc_frac;

   logic                     vld_p2;
   logic [CH*IDX_W-1:0]      idx_p2;
   logic [CH*DATA_W-1:0]     pix_p2;
   logic [CH*DATA_W-1:0]     low_p2;
   logic [CH*(DATA_W+1)-1:0] high_p2;
   logic [CH*DATA_W-1:0]     frac_p2;

   assign blank = ~i_vs | ~i_hs;

   // ------------------------------------------------------------------------
   // Configuration FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CFG_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign chk_k_nxt = chk_k + IDX_W'(1);

   always_comb begin
      state_nxt = state;
      shadow_we = 1'b0;
      chk_step  = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      swap      = 1'b0;
      case (state)
         CFG_IDLE: begin
            shadow_we = cfg_we && (cfg_addr != '0);
            if (cfg_commit) begin
               state_nxt = CFG_CHECK;
               err_clr   = 1'b1;
            end
         end
         CFG_CHECK: begin
            if (!(shadow_bp[chk_k] < shadow_bp[chk_k_nxt])) begin
               err_set   = 1'b1;
               state_nxt = CFG_IDLE;
            end else if (chk_k == IDX_W'(NUM_SEG-2)) begin
               state_nxt = CFG_WAIT_VS;
            end else begin
               chk_step = 1'b1;
            end
         end
         CFG_WAIT_VS: begin
            if (!i_vs) begin
               swap      = 1'b1;
               state_nxt = CFG_IDLE;
            end
         end
         default: state_nxt = CFG_IDLE;
      endcase
   end

   // Tables, check pointer and error flag. A same-cycle write and commit is
   // fine: the write lands on this edge and CHECK starts reading next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_SEG; k++) begin
            active_bp[k] <= DATA_W'(default_bp(k, DATA_W, NUM_SEG));
            shadow_bp[k] <= DATA_W'(default_bp(k, DATA_W, NUM_SEG));
         end
         chk_k <= '0;
         err_q <= 1'b0;
      end else begin
         if (shadow_we) begin
            shadow_bp[cfg_addr] <= cfg_data;
         end
         if (swap) begin
            for (int k = 0; k < NUM_SEG; k++) begin
               active_bp[k] <= shadow_bp[k];
            end
         end
         if (state == CFG_IDLE) begin
            chk_k <= '0;
         end else if (chk_step) begin
            chk_k <= chk_k_nxt;
         end
         if (err_clr) begin
            err_q <= 1'b0;
         end else if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   assign cfg_busy = (state != CFG_IDLE);
   assign cfg_err  = err_q;

   always_comb begin
      active_flat = '0;
      for (int k = 0; k < NUM_SEG; k++) begin
         active_flat[k*DATA_W +: DATA_W] = active_bp[k];
      end
   end

   always_comb begin
      mask_nxt = '0;
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < NUM_SEG; k++) begin
            mask_nxt[c*NUM_SEG + k] = (active_bp[k] <= pix_in[c*DATA_W +: DATA_W]);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 1: pixel and compare mask
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         pix_p1  <= '0;
         mask_p1 <= '0;
      end else if (blank) begin
         vld_p1  <= 1'b0;
         pix_p1  <= '0;
         mask_p1 <= '0;
      end else begin
         vld_p1 <= en;
         if (en) begin
            pix_p1  <= pix_in;
            mask_p1 <= mask_nxt;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_enc
      pwl_seg_encoder #(
         .DATA_W  (DATA_W),
         .NUM_SEG (NUM_SEG),
         .IDX_W   (IDX_W)
      ) u_enc (
         .mask    (mask_p1[c*NUM_SEG +: NUM_SEG]),
         .pix     (pix_p1[c*DATA_W +: DATA_W]),
         .bp_flat (active_flat),
         .idx     (enc_idx[c*IDX_W +: IDX_W]),
         .low     (enc_low[c*DATA_W +: DATA_W]),
         .high    (enc_high[c*(DATA_W+1) +: (DATA_W+1)]),
         .frac    (enc_frac[c*DATA_W +: DATA_W])
      );
   end

   // ------------------------------------------------------------------------
   // Stage 2: index, bounds and offset; data hold while not valid
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         idx_p2  <= '0;
         pix_p2  <= '0;
         low_p2  <= '0;
         high_p2 <= '0;
         frac_p2 <= '0;
      end else if (blank) begin
         vld_p2  <= 1'b0;
         idx_p2  <= '0;
         pix_p2  <= '0;
         low_p2  <= '0;
         high_p2 <= '0;
         frac_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            idx_p2  <= enc_idx;
            pix_p2  <= pix_p1;
            low_p2  <= enc_low;
            high_p2 <= enc_high;
            frac_p2 <= enc_frac;
         end
      end
   end

   assign o_valid = vld_p2;
   assign o_idx   = idx_p2;
   assign o_pix   = pix_p2;
   assign o_low   = low_p2;
   assign o_high  = high_p2;
   assign o_frac  = frac_p2;

endmodule

// File: tb/tb_pwl_segment_search.sv
// ----------------------------------------------------------------------------
// tb_pwl_segment_search
// Scoreboard bench: the driver pushes expected results when it issues a pixel
// triple, the monitor pops and compares whenever o_valid is seen.
// ----------------------------------------------------------------------------
module tb_pwl_segment_search;

   localparam int DATA_W  = 10;
   localparam int NUM_SEG = 32;
   localparam int IDX_W   = 5;
   localparam int CH      = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_hs = 1'b1;
   logic i_vs = 1'b1;
   logic en = 1'b0;
   logic [CH*DATA_W-1:0] pix_in = '0;
   logic cfg_we = 1'b0;
   logic [IDX_W-1:0] cfg_addr = '0;
   logic [DATA_W-1:0] cfg_data = '0;
   logic cfg_commit = 1'b0;
   logic cfg_busy, cfg_err, o_valid;
   logic [CH*IDX_W-1:0]      o_idx;
   logic [CH*DATA_W-1:0]     o_pix, o_low, o_frac;
   logic [CH*(DATA_W+1)-1:0] o_high;

   pwl_segment_search #(
      .DATA_W(DATA_W), .NUM_SEG(NUM_SEG), .IDX_W(IDX_W), .CH(CH)
   ) dut (
      .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .en(en), .pix_in(pix_in),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .o_valid(o_valid), .o_idx(o_idx), .o_pix(o_pix), .o_low(o_low),
      .o_high(o_high), .o_frac(o_frac)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH*IDX_W-1:0]      idx;
      logic [CH*DATA_W-1:0]     pix;
      logic [CH*DATA_W-1:0]     low;
      logic [CH*(DATA_W+1)-1:0] high;
      logic [CH*DATA_W-1:0]     frac;
      int                       cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc_cnt = 0;
   int   tb_bp [NUM_SEG];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic model_default();
      for (int k = 0; k < NUM_SEG; k++) tb_bp[k] = k * 32;
   endtask

   task automatic model(input int p, output int idx, output int low, output int high);
      idx = 0;
      for (int k = 0; k < NUM_SEG; k++) if (tb_bp[k] <= p) idx = k;
      low  = tb_bp[idx];
      high = (idx == NUM_SEG-1) ? 1024 : tb_bp[idx+1];
   endtask

   // Issue one triple; expected values come from the reference table model.
   task automatic send3(input int p0, input int p1, input int p2);
      exp_t e;
      int ps[3];
      int idx, low, high;
      ps[0] = p0; ps[1] = p1; ps[2] = p2;
      @(negedge clk);
      en = 1'b1;
      for (int c = 0; c < CH; c++) begin
         pix_in[c*DATA_W +: DATA_W] = DATA_W'(ps[c]);
         model(ps[c], idx, low, high);
         e.idx[c*IDX_W +: IDX_W]              = IDX_W'(idx);
         e.pix[c*DATA_W +: DATA_W]            = DATA_W'(ps[c]);
         e.low[c*DATA_W +: DATA_W]            = DATA_W'(low);
         e.high[c*(DATA_W+1) +: (DATA_W+1)]   = (DATA_W+1)'(high);
         e.frac[c*DATA_W +: DATA_W]           = DATA_W'(ps[c] - low);
      end
      e.cyc = cyc_cnt;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en = 1'b0;
      end
   endtask

   task automatic cfg_write(input int a, input int d);
      @(negedge clk);
      en = 1'b0;
      cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_data = DATA_W'(d);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic cfg_go();
      @(negedge clk);
      en = 1'b0;
      cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, 64'(o_valid), 64'd0);
      chk({tag, "_idx"},   64'(o_idx),   64'd0);
      chk({tag, "_pix"},   64'(o_pix),   64'd0);
      chk({tag, "_low"},   64'(o_low),   64'd0);
      chk({tag, "_high"},  64'(o_high),  64'd0);
      chk({tag, "_frac"},  64'(o_frac),  64'd0);
   endtask

   // Monitor: compare every presented output against the head of the queue.
   always @(posedge clk) begin
      #1;
      if (o_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=1 required=0 t=%0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("out_idx",  64'(o_idx),  64'(mon_e.idx));
            chk("out_pix",  64'(o_pix),  64'(mon_e.pix));
            chk("out_low",  64'(o_low),  64'(mon_e.low));
            chk("out_high", 64'(o_high), 64'(mon_e.high));
            chk("out_frac", 64'(o_frac), 64'(mon_e.frac));
            chk("latency",  64'(cyc_cnt - mon_e.cyc), 64'd2);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      exp_t e;
      model_default();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      chk("reset_busy", 64'(cfg_busy), 64'd0);
      chk("reset_err",  64'(cfg_err),  64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: hand-computed triple {0,100,1023}
      @(negedge clk);
      en = 1'b1;
      pix_in = {10'd1023, 10'd100, 10'd0};
      e.idx  = {5'd31, 5'd3, 5'd0};
      e.pix  = {10'd1023, 10'd100, 10'd0};
      e.low  = {10'd992, 10'd96, 10'd0};
      e.high = {11'd1024, 11'd128, 11'd32};
      e.frac = {10'd31, 10'd4, 10'd0};
      e.cyc  = cyc_cnt;
      sb_q.push_back(e);
      idle(4);
      // Outputs hold the last result while o_valid is low
      chk("hold_valid", 64'(o_valid), 64'd0);
      chk("hold_idx",   64'(o_idx),   64'(e.idx));
      chk("hold_high",  64'(o_high),  64'(e.high));

      // Test 2: back-to-back ramp
      for (int i = 0; i < 64; i++) send3(i*16, 1023 - i*16, (i*16 + 31) % 1024);
      idle(4);

      // Test 3: one hsync blanking cycle mid-stream
      for (int i = 0; i < 6; i++) send3(i*50, i*50 + 7, 1000 - i*50);
      @(negedge clk);
      en = 1'b1;
      pix_in = {10'd500, 10'd500, 10'd500};
      i_hs = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
      check_zero_outputs("blank");
      @(negedge clk);
      i_hs = 1'b1;
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("blank2_valid", 64'(o_valid), 64'd0);
      for (int i = 0; i < 6; i++) send3(i*60 + 3, i*60 + 33, 1023 - i*60);
      idle(4);

      // Test 4: valid commit, swap on vsync
      cfg_write(1, 8);
      cfg_go();
      #1;
      chk("commit_busy", 64'(cfg_busy), 64'd1);
      chk("commit_err",  64'(cfg_err),  64'd0);
      send3(20, 20, 20);
      idle(40);
      chk("wait_vs_busy", 64'(cfg_busy), 64'd1);
      send3(20, 20, 20);
      idle(4);
      @(negedge clk);
      i_vs = 1'b0;
      @(posedge clk);
      #1;
      chk("swap_busy", 64'(cfg_busy), 64'd0);
      @(negedge clk);
      i_vs = 1'b1;
      tb_bp[1] = 8;
      send3(20, 20, 40);
      idle(4);

      // Test 5: non-monotonic table rejected
      cfg_write(5, 100);
      cfg_go();
      busy_cnt = 1;
      #1;
      while (cfg_busy === 1'b1 && busy_cnt < 60) begin
         @(posedge clk);
         #1;
         if (cfg_busy === 1'b1) busy_cnt++;
      end
      chk("reject_busy_cycles", 64'(busy_cnt), 64'd5);
      chk("reject_err", 64'(cfg_err), 64'd1);
      send3(140, 140, 170);
      idle(4);
      cfg_write(5, 150);
      cfg_go();
      #1;
      chk("recommit_err", 64'(cfg_err), 64'd0);
      idle(40);
      chk("recommit_busy", 64'(cfg_busy), 64'd1);

      // Test 6: reset while waiting for vsync
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero_outputs("midrst");
      chk("midrst_busy", 64'(cfg_busy), 64'd0);
      chk("midrst_err",  64'(cfg_err),  64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_default();
      send3(20, 140, 8);
      idle(4);

      chk("queue_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
